// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags, synchronous flush,
// sticky overflow/underflow flags and selectable first-word-fall-through.
module fifo_param #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int FWFT            = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empt,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  // Thresholds sized to the count width so the flag compares stay width-exact.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // A read is taken only from a non-empty FIFO; a write into a full FIFO is
  // taken only when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empt;
  assign wr_acc = wr & (~full | rd_acc);

  // Status flags come straight from the registered count, so none of them
  // has a combinational path from wr or rd.
  assign empt         = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

  // Pointers, occupancy and sticky error flags; flush empties the FIFO and
  // ignores that cycle's requests without raising errors for them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && !wr_acc) overflow  <= 1'b1;
      if (rd && !rd_acc) underflow <= 1'b1;
    end
  end

  // Storage array: cleared by reset, untouched by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      // Standard mode: the head word is registered out on an accepted read.
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_out <= '0;
        end else if (!flush && rd_acc) begin
          data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end
    end else begin : g_fwft_read
      // Fall-through mode: the head word is always presented; rd just pops it.
      assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: drives a standard-read and a fall-through instance with the
// same stimulus and compares both against a queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst, wr, rd, flush;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, dout1;
  logic          empt0, full0, ae0, af0, ovf0, unf0;
  logic          empt1, full1, ae1, af1, ovf1, unf1;
  logic [AW:0]   cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, registered read word, sticky errors.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
               .ALMOST_EMPTY_TH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .flush(flush),
    .data_out(dout0), .empt(empt0), .full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(cnt0), .overflow(ovf0), .underflow(unf0));

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF),
               .ALMOST_EMPTY_TH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd), .flush(flush),
    .data_out(dout1), .empt(empt1), .full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(cnt1), .overflow(ovf1), .underflow(unf1));

  // One clock: drive inputs, let the edge happen, update the model, then
  // return at the falling edge where outputs are sampled.
  task automatic step(input bit r, input bit w, input bit rr, input bit f,
                      input logic [DW-1:0] d);
    bit ra, wa;
    rst = r; wr = w; rd = rr; flush = f; data_in = d;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_unf = 0;
    end else if (f) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      ra = rr && (q.size() != 0);
      wa = w && ((q.size() < DEPTH) || ra);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      if (w && !wa)  m_ovf = 1;
      if (rr && !ra) m_unf = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 1, 1, 0, 32'h1234);
    step(0, 0, 0, 0, '0);
    checks++; if (cnt0 !== 4'd0)  begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", cnt0); end
    checks++; if (empt0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_empt got=%b exp=1", empt0); end
    checks++; if (ae0 !== 1'b1)   begin failures++; $display("[TB] FAIL reset_almost_empty got=%b exp=1", ae0); end
    checks++; if (full0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full0); end
    checks++; if (af0 !== 1'b0)   begin failures++; $display("[TB] FAIL reset_almost_full got=%b exp=0", af0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_errors got=%b%b exp=00", ovf0, unf0); end
    checks++; if (dout0 !== 32'h0) begin failures++; $display("[TB] FAIL reset_dout_std got=%h exp=0", dout0); end
    checks++; if (dout1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_dout_fwft got=%h exp=0", dout1); end
  endtask

  task automatic test_fill_drain();
    step(0, 0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 0, 32'(i) * 32'h11);
      checks++; if (cnt0 !== 4'(i)) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=%0d", cnt0, i); end
      checks++; if (af0 !== (i >= 6)) begin failures++; $display("[TB] FAIL fill_almost_full i=%0d got=%b", i, af0); end
      checks++; if (full0 !== (i == 8)) begin failures++; $display("[TB] FAIL fill_full i=%0d got=%b", i, full0); end
    end
    step(1, 1, 0, 0, 32'h99);
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("[TB] FAIL fill_overflow got=%b exp=1", ovf0); end
    checks++; if (cnt0 !== 4'd8) begin failures++; $display("[TB] FAIL fill_count_after_ovf got=%0d exp=8", cnt0); end
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, 0, '0);
      checks++; if (dout0 !== 32'(i) * 32'h11) begin failures++; $display("[TB] FAIL drain_data got=%h exp=%h", dout0, 32'(i) * 32'h11); end
    end
    checks++; if (empt0 !== 1'b1 || unf0 !== 1'b0) begin failures++; $display("[TB] FAIL drain_end got empt=%b unf=%b exp 1/0", empt0, unf0); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp [5];
    step(0, 0, 0, 0, '0);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 5; k++) begin
        exp[k] = $urandom;
        step(1, 1, 0, 0, exp[k]);
      end
      for (int k = 0; k < 5; k++) begin
        step(1, 0, 1, 0, '0);
        checks++; if (dout0 !== exp[k]) begin failures++; $display("[TB] FAIL wrap_data b=%0d k=%0d got=%h exp=%h", b, k, dout0, exp[k]); end
      end
      checks++; if (cnt0 !== 4'd0 || empt0 !== 1'b1) begin failures++; $display("[TB] FAIL wrap_empty b=%0d count=%0d empt=%b exp 0/1", b, cnt0, empt0); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp [8];
    step(0, 0, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      exp[k] = $urandom;
      step(1, 1, 0, 0, exp[k]);
    end
    step(1, 1, 1, 0, 32'hAA);
    checks++; if (cnt0 !== 4'd8 || full0 !== 1'b1) begin failures++; $display("[TB] FAIL simul_full count=%0d full=%b exp 8/1", cnt0, full0); end
    checks++; if (dout0 !== exp[0]) begin failures++; $display("[TB] FAIL simul_full_data got=%h exp=%h", dout0, exp[0]); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("[TB] FAIL simul_full_ovf got=%b exp=0", ovf0); end
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 1, 0, '0);
      checks++; if (dout0 !== ((k == 8) ? 32'hAA : exp[k])) begin failures++; $display("[TB] FAIL simul_drain k=%0d got=%h", k, dout0); end
    end
    step(1, 1, 1, 0, 32'hBB);
    checks++; if (cnt0 !== 4'd1 || unf0 !== 1'b1) begin failures++; $display("[TB] FAIL simul_empty count=%0d unf=%b exp 1/1", cnt0, unf0); end
    checks++; if (dout0 !== 32'hAA) begin failures++; $display("[TB] FAIL simul_empty_data got=%h exp=aa", dout0); end
    checks++; if (dout1 !== 32'hBB) begin failures++; $display("[TB] FAIL simul_empty_fwft got=%h exp=bb", dout1); end
  endtask

  task automatic test_thresholds();
    step(0, 0, 0, 0, '0);
    for (int i = 1; i <= 7; i++) begin
      step(1, 1, 0, 0, $urandom);
      checks++; if (ae0 !== (i <= AE) || ae1 !== (i <= AE)) begin failures++; $display("[TB] FAIL thresh_almost_empty count=%0d got=%b%b", i, ae0, ae1); end
      checks++; if (af0 !== (i >= AF) || af1 !== (i >= AF)) begin failures++; $display("[TB] FAIL thresh_almost_full count=%0d got=%b%b", i, af0, af1); end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp [8];
    step(0, 0, 0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      exp[k] = $urandom;
      step(1, 1, 0, 0, exp[k]);
    end
    step(1, 1, 0, 0, 32'h99);
    for (int k = 0; k < 4; k++) step(1, 0, 1, 0, '0);
    checks++; if (cnt0 !== 4'd4 || ovf0 !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre count=%0d ovf=%b exp 4/1", cnt0, ovf0); end
    step(1, 1, 1, 1, 32'h55);
    checks++; if (cnt0 !== 4'd0 || empt0 !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty count=%0d empt=%b exp 0/1", cnt0, empt0); end
    checks++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin failures++; $display("[TB] FAIL flush_errors got=%b%b exp=00", ovf0, unf0); end
    checks++; if (dout0 !== exp[3]) begin failures++; $display("[TB] FAIL flush_dout_hold got=%h exp=%h", dout0, exp[3]); end
    step(1, 1, 0, 0, 32'hCC);
    checks++; if (dout1 !== 32'hCC) begin failures++; $display("[TB] FAIL flush_fwft_head got=%h exp=cc", dout1); end
    step(1, 0, 1, 0, '0);
    checks++; if (dout0 !== 32'hCC) begin failures++; $display("[TB] FAIL flush_next_read got=%h exp=cc", dout0); end
  endtask

  task automatic test_fwft();
    step(0, 0, 0, 0, '0);
    step(1, 1, 0, 0, 32'hDEAD);
    checks++; if (empt1 !== 1'b0 || dout1 !== 32'hDEAD) begin failures++; $display("[TB] FAIL fwft_fall empt=%b dout=%h exp 0/dead", empt1, dout1); end
    step(1, 0, 0, 0, '0);
    checks++; if (dout1 !== 32'hDEAD) begin failures++; $display("[TB] FAIL fwft_hold got=%h exp=dead", dout1); end
    step(1, 0, 1, 0, '0);
    checks++; if (empt1 !== 1'b1) begin failures++; $display("[TB] FAIL fwft_pop_empt got=%b exp=1", empt1); end
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, $urandom | 32'h1);
    step(0, 0, 0, 0, '0);
    checks++; if (cnt1 !== 4'd0 || dout1 !== 32'h0) begin failures++; $display("[TB] FAIL fwft_reset count=%0d dout=%h exp 0/0", cnt1, dout1); end
  endtask

  task automatic test_random();
    int bias;
    bit r, w, rr, f;
    step(0, 0, 0, 0, '0);
    for (int n = 0; n < 600; n++) begin
      bias = ((n / 50) % 2 == 1) ? 75 : 25;
      r  = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < bias);
      rr = ($urandom_range(0, 99) < (100 - bias));
      f  = ($urandom_range(0, 99) < 2);
      step(r, w, rr, f, $urandom);
      checks++; if (cnt0 !== 4'(q.size()) || cnt1 !== 4'(q.size())) begin failures++; $display("[TB] FAIL rand_count n=%0d got=%0d/%0d exp=%0d", n, cnt0, cnt1, q.size()); end
      checks++; if (empt0 !== (q.size() == 0) || full0 !== (q.size() == DEPTH)) begin failures++; $display("[TB] FAIL rand_empt_full n=%0d got=%b%b", n, empt0, full0); end
      checks++; if (ae0 !== (q.size() <= AE) || af0 !== (q.size() >= AF)) begin failures++; $display("[TB] FAIL rand_almost n=%0d got=%b%b", n, ae0, af0); end
      checks++; if (ovf0 !== m_ovf || unf0 !== m_unf || ovf1 !== m_ovf || unf1 !== m_unf) begin failures++; $display("[TB] FAIL rand_errors n=%0d got=%b%b%b%b exp=%b%b", n, ovf0, unf0, ovf1, unf1, m_ovf, m_unf); end
      checks++; if (dout0 !== m_dout) begin failures++; $display("[TB] FAIL rand_dout_std n=%0d got=%h exp=%h", n, dout0, m_dout); end
      if (q.size() != 0) begin
        checks++; if (dout1 !== q[0] || empt1 !== 1'b0) begin failures++; $display("[TB] FAIL rand_dout_fwft n=%0d got=%h exp=%h", n, dout1, q[0]); end
      end
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; flush = 1'b0; data_in = '0;
    m_dout = '0; m_ovf = 0; m_unf = 0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_thresholds();
    test_flush();
    test_fwft();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
